// File: rtl/sha3_block_packer.sv
// Packs a 64-bit little-endian word stream into SHA-3 rate blocks with pad10*1 padding.
// Optional macro SHA3_PACKER_STATS_EN builds the o_blocks handshake counter.
module sha3_block_packer #(
    parameter int         RATE_LANES  = 17,
    parameter logic [7:0] DOMAIN_BYTE = 8'h06
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [63:0] i_word,
    input  logic        i_last,
    input  logic [3:0]  i_last_bytes,
    output logic        o_good,
    input  logic        o_ready,
    output logic        o_last,
    output logic [63:0] osa [5],
    output logic [63:0] osb [5],
    output logic [63:0] osc [5],
    output logic [63:0] osd [5],
    output logic [63:0] ose [5],
    output logic [31:0] o_blocks
);
    // state | meaning
    // FILL  | accepting message words into lanes[cnt]
    // EMIT  | block presented on o_good until o_ready
    // PAD   | one cycle building the extra padding-only block
    typedef enum logic [1:0] {FILL, EMIT, PAD} state_t;

    localparam int         LAST     = RATE_LANES - 1;
    localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);

    if (!(RATE_LANES == 9 || RATE_LANES == 13 || RATE_LANES == 17 ||
          RATE_LANES == 18 || RATE_LANES == 21)) begin : g_bad_rate
        $error("sha3_block_packer: illegal RATE_LANES %0d", RATE_LANES);
    end

    state_t      state;
    logic [4:0]  cnt;
    logic        pad_pending;
    logic [63:0] lanes      [25];
    logic [63:0] lanes_next [25];
    logic [63:0] word_masked;
    logic [3:0]  b;
    logic        accept;

    assign accept = i_valid && i_ready;
    assign b      = (i_last_bytes > 4'd8) ? 4'd8 : i_last_bytes;

    always_comb begin
        word_masked = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < b) word_masked[8*k +: 8] = i_word[8*k +: 8];
        end
    end

    // Lanes above cnt are always zero here, so padding only needs to OR bytes in.
    always_comb begin
        lanes_next = lanes;
        case (state)
            FILL: begin
                if (accept) begin
                    if (!i_last) begin
                        lanes_next[cnt] = i_word;
                    end else begin
                        lanes_next[cnt] = word_masked;
                        if (b != 4'd8) begin
                            lanes_next[cnt] = lanes_next[cnt] |
                                              (64'(DOMAIN_BYTE) << {b[2:0], 3'b000});
                            lanes_next[LAST][63:56] = lanes_next[LAST][63:56] | 8'h80;
                        end else if (cnt != LAST_IDX) begin
                            lanes_next[cnt + 5'd1][7:0] = DOMAIN_BYTE;
                            lanes_next[LAST][63:56] = lanes_next[LAST][63:56] | 8'h80;
                        end
                    end
                end
            end
            EMIT: begin
                if (o_ready) begin
                    for (int l = 0; l < 25; l++) lanes_next[l] = '0;
                end
            end
            PAD: begin
                for (int l = 0; l < 25; l++) lanes_next[l] = '0;
                lanes_next[0][7:0]      = DOMAIN_BYTE;
                lanes_next[LAST][63:56] = lanes_next[LAST][63:56] | 8'h80;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            cnt         <= '0;
            pad_pending <= 1'b0;
            i_ready     <= 1'b1;
            o_good      <= 1'b0;
            o_last      <= 1'b0;
            for (int l = 0; l < 25; l++) lanes[l] <= '0;
        end else begin
            lanes <= lanes_next;
            case (state)
                FILL: begin
                    if (accept) begin
                        if (i_last) begin
                            // A full final word that fills the block leaves no room for padding.
                            if (b == 4'd8 && cnt == LAST_IDX) begin
                                pad_pending <= 1'b1;
                                o_last      <= 1'b0;
                            end else begin
                                o_last <= 1'b1;
                            end
                            state   <= EMIT;
                            o_good  <= 1'b1;
                            i_ready <= 1'b0;
                        end else if (cnt == LAST_IDX) begin
                            state   <= EMIT;
                            o_good  <= 1'b1;
                            o_last  <= 1'b0;
                            i_ready <= 1'b0;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                EMIT: begin
                    if (o_ready) begin
                        o_good <= 1'b0;
                        o_last <= 1'b0;
                        cnt    <= '0;
                        if (pad_pending) begin
                            state       <= PAD;
                            pad_pending <= 1'b0;
                        end else begin
                            state   <= FILL;
                            i_ready <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    state  <= EMIT;
                    o_good <= 1'b1;
                    o_last <= 1'b1;
                end
                default: state <= FILL;
            endcase
        end
    end

    always_comb begin
        for (int x = 0; x < 5; x++) begin
            osa[x] = lanes[x];
            osb[x] = lanes[x + 5];
            osc[x] = lanes[x + 10];
            osd[x] = lanes[x + 15];
            ose[x] = lanes[x + 20];
        end
    end

`ifdef SHA3_PACKER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)                  o_blocks <= '0;
        else if (o_good && o_ready) o_blocks <= o_blocks + 32'd1;
    end
`else
    assign o_blocks = '0;
`endif

endmodule

// File: tb/tb_sha3_block_packer.sv
// Self-checking bench for sha3_block_packer: random word streams against a byte-level SHA-3 padding model.
module tb_sha3_block_packer;
    localparam int R  = 17;
    localparam int RB = R * 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [63:0] i_word;
    logic        i_last;
    logic [3:0]  i_last_bytes;
    logic        o_good;
    logic        o_ready;
    logic        o_last;
    logic [63:0] osa [5];
    logic [63:0] osb [5];
    logic [63:0] osc [5];
    logic [63:0] osd [5];
    logic [63:0] ose [5];
    logic [31:0] o_blocks;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_blocks = 0;

    logic [63:0] msg_words [64];
    logic [63:0] exp_lane [$];
    bit          exp_last [$];

    sha3_block_packer #(.RATE_LANES(R), .DOMAIN_BYTE(8'h06)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
        .i_word(i_word), .i_last(i_last), .i_last_bytes(i_last_bytes),
        .o_good(o_good), .o_ready(o_ready), .o_last(o_last),
        .osa(osa), .osb(osb), .osc(osc), .osd(osd), .ose(ose),
        .o_blocks(o_blocks)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] lane_of(int l);
        case (l / 5)
            0: return osa[l % 5];
            1: return osb[l % 5];
            2: return osc[l % 5];
            3: return osd[l % 5];
            default: return ose[l % 5];
        endcase
    endfunction

    function automatic logic [31:0] stats_exp();
`ifdef SHA3_PACKER_STATS_EN
        return 32'(exp_blocks);
`else
        return 32'd0;
`endif
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0;
        i_word = '0; i_last = 1'b0; i_last_bytes = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_blocks = 0;
    endtask

    // Message bytes + pad10*1 with domain 0x06, cut into rate blocks.
    task automatic build_model(int nw, logic [3:0] lb);
        logic [7:0] q [$];
        int n, pad;
        logic [63:0] lane;
        exp_lane.delete();
        exp_last.delete();
        for (int i = 0; i < nw; i++) begin
            n = (i == nw - 1) ? ((lb > 4'd8) ? 8 : int'(lb)) : 8;
            for (int k = 0; k < n; k++) q.push_back(msg_words[i][8*k +: 8]);
        end
        pad = RB - (q.size() % RB);
        if (pad == 1) q.push_back(8'h86);
        else begin
            q.push_back(8'h06);
            for (int k = 0; k < pad - 2; k++) q.push_back(8'h00);
            q.push_back(8'h80);
        end
        for (int j = 0; j < q.size() / RB; j++) begin
            for (int l = 0; l < 25; l++) begin
                lane = '0;
                if (l < R) for (int k = 0; k < 8; k++) lane[8*k +: 8] = q[j*RB + l*8 + k];
                exp_lane.push_back(lane);
            end
            exp_last.push_back(j == q.size() / RB - 1);
        end
    endtask

    // mode 0: random valid/ready; 1: always valid/ready; 2: ready held low 5 cycles per block
    task automatic run_msg(string name, int nw, logic [3:0] lb, int mode);
        int idx = 0, blk = 0, cyc = 0, hold = 0, nblk, bad;
        bit exp_good_next = 0;
        build_model(nw, lb);
        nblk = exp_last.size();
        while ((idx < nw || blk < nblk) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            n_checks++;
            if (o_blocks !== stats_exp()) begin
                n_fail++;
                $display("FAIL %s o_blocks: got %0d want %0d", name, o_blocks, stats_exp());
            end
            if (exp_good_next) begin
                n_checks++;
                if (o_good !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s latency: o_good got %b want 1", name, o_good);
                end
                exp_good_next = 0;
            end
            if (o_good === 1'b1) begin
                n_checks++;
                if (blk >= nblk) begin
                    n_fail++;
                    $display("FAIL %s extra block: got block %0d want %0d blocks", name, blk, nblk);
                end else begin
                    bad = -1;
                    for (int l = 24; l >= 0; l--) if (lane_of(l) !== exp_lane[blk*25 + l]) bad = l;
                    if (bad >= 0) begin
                        n_fail++;
                        $display("FAIL %s lanes blk %0d lane %0d: got %h want %h", name, blk, bad,
                                 lane_of(bad), exp_lane[blk*25 + bad]);
                    end
                    n_checks++;
                    if (o_last !== exp_last[blk]) begin
                        n_fail++;
                        $display("FAIL %s o_last blk %0d: got %b want %b", name, blk, o_last, exp_last[blk]);
                    end
                end
                n_checks++;
                if (i_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s i_ready during emit: got %b want 0", name, i_ready);
                end
                case (mode)
                    1: o_ready = 1'b1;
                    2: o_ready = (hold >= 5);
                    default: o_ready = ($urandom_range(0, 2) != 0);
                endcase
                if (o_ready) begin
                    blk++;
                    exp_blocks++;
                    hold = 0;
                end else hold++;
            end else begin
                o_ready = 1'b0;
            end
            if (idx < nw) begin
                i_valid      = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
                i_word       = msg_words[idx];
                i_last       = (idx == nw - 1);
                i_last_bytes = i_last ? lb : 4'($urandom_range(0, 15));
                if (i_valid && i_ready) begin
                    if ((idx % R) == R - 1 || i_last) exp_good_next = 1;
                    idx++;
                end
            end else begin
                i_valid = 1'b0;
                i_word  = 64'($urandom);
            end
        end
        n_checks++;
        if (cyc >= 3000) begin
            n_fail++;
            $display("FAIL %s timeout: got %0d words %0d blocks want %0d words %0d blocks",
                     name, idx, blk, nw, nblk);
        end
        @(negedge clk);
        i_valid = 1'b0;
        o_ready = 1'b0;
    endtask

    task automatic test_reset();
        int bad = -1;
        do_reset();
        for (int l = 0; l < 25; l++) if (lane_of(l) !== 64'd0) bad = l;
        n_checks++;
        if (bad >= 0) begin n_fail++; $display("FAIL reset lanes: lane %0d got %h want 0", bad, lane_of(bad)); end
        n_checks++;
        if (o_good !== 1'b0) begin n_fail++; $display("FAIL reset o_good: got %b want 0", o_good); end
        n_checks++;
        if (o_last !== 1'b0) begin n_fail++; $display("FAIL reset o_last: got %b want 0", o_last); end
        n_checks++;
        if (i_ready !== 1'b1) begin n_fail++; $display("FAIL reset i_ready: got %b want 1", i_ready); end
        n_checks++;
        if (o_blocks !== 32'd0) begin n_fail++; $display("FAIL reset o_blocks: got %0d want 0", o_blocks); end
    endtask

    task automatic test_empty();
        msg_words[0] = {$urandom, $urandom};
        run_msg("empty", 1, 4'd0, 1);
    endtask

    task automatic test_abc();
        msg_words[0] = 64'h0000_0000_0063_6261;
        run_msg("abc", 1, 4'd3, 1);
    endtask

    task automatic test_full_plus_pad();
        for (int i = 0; i < R; i++) msg_words[i] = {$urandom, $urandom};
        run_msg("full_pad", R, 4'd8, 1);
    endtask

    task automatic test_full_b7();
        for (int i = 0; i < R; i++) msg_words[i] = {$urandom, $urandom};
        run_msg("full_b7", R, 4'd7, 1);
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 40; i++) msg_words[i] = {$urandom, $urandom};
        run_msg("backpressure", 40, 4'd5, 2);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            i_valid = 1'b1; i_last = 1'b0; i_word = {$urandom, $urandom};
        end
        do_reset();
        n_checks++;
        if (o_good !== 1'b0 || i_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid flags: got good=%b ready=%b want good=0 ready=1", o_good, i_ready);
        end
        msg_words[0] = 64'h0000_0000_0063_6261;
        run_msg("reset_abc", 1, 4'd3, 1);
    endtask

    task automatic test_random();
        int nw;
        for (int t = 0; t < 10; t++) begin
            nw = $urandom_range(1, 60);
            for (int i = 0; i < nw; i++) msg_words[i] = {$urandom, $urandom};
            run_msg("random", nw, 4'($urandom_range(0, 12)), t % 3);
        end
    endtask

    task automatic test_back_to_back();
        msg_words[0] = {$urandom, $urandom};
        run_msg("b2b_a", 1, 4'd8, 1);
        for (int i = 0; i < 2*R; i++) msg_words[i] = {$urandom, $urandom};
        run_msg("b2b_b", 2*R, 4'd8, 1);
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; o_ready = 1'b0;
        i_word = '0; i_last = 1'b0; i_last_bytes = '0;
        test_reset();
        test_empty();
        test_abc();
        test_full_plus_pad();
        test_full_b7();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
